// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase response mux with built-in default slave
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1,
  parameter int DATA_W     = 32
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [SEL_W-1:0]             sel,
  input  logic [1:0]                   htrans,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s,
  input  logic [NUM_SLAVES-1:0]        hresp_s,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready,
  output logic                         hresp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] data_sel, data_sel_nxt;
  logic             sel_mapped;
  logic [DATA_W-1:0] slv_rdata;
  logic             slv_ready;
  logic             slv_resp;

  assign sel_mapped = (32'(sel) < 32'(NUM_SLAVES));

  // Compare-and-pick keeps an unmapped data_sel from ever indexing the buses.
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (data_sel == SEL_W'(k)) begin
        slv_rdata = hrdata_s[k*DATA_W +: DATA_W];
        slv_ready = hreadyout_s[k];
        slv_resp  = hresp_s[k];
      end
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state)
      ST_SLAVE: begin
        hready = slv_ready;
        hresp  = slv_resp;
        hrdata = slv_rdata;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    data_sel_nxt = data_sel;
    if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (hready) begin
      if (sel_mapped) begin
        state_nxt    = ST_SLAVE;
        data_sel_nxt = sel;
      end else if (htrans[1]) begin
        state_nxt = ST_ERR1;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      data_sel <= '0;
    end else begin
      state    <= state_nxt;
      data_sel <= data_sel_nxt;
    end
  end

endmodule
